uart_tx_queue: RTL and testbench

- Transmit-side byte queue between the b1 CPU and the osdvu uart core. It is the counterpart of the receive ring buffer.
- The CPU pushes bytes with a one-cycle write strobe.
- The block stores bytes in a ring buffer and drains them one at a time through the uart transmit / tx_byte / is_transmitting handshake.
- It reports full, empty, fill count and a sticky overflow flag.

---
 rtl/uart_tx_queue.sv | 165 ++++++++++++++++
 tb/tb_uart_tx_queue.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_queue.sv
// Transmit byte queue: CPU pushes bytes into a ring buffer, an FSM feeds them to the uart core.
// Define UART_TXQ_CRLF_EN to follow every transmitted CR (8'h0D) with an injected LF (8'h0A).
module uart_tx_queue #(
  parameter int DEPTH_LOG2   = 8,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                CLK,
  input  logic                reset_n,
  input  logic                wr_en,
  input  logic [7:0]          wr_data,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_LOG2:0] count,
  output logic                overflow,
  input  logic                clear_overflow,
  output logic                transmit,
  output logic [7:0]          tx_byte,
  input  logic                is_transmitting
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int TMO_W = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TIMEOUT - 1);

`ifdef UART_TXQ_CRLF_EN
  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_BUSY, WAIT_IDLE, LF} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_BUSY, WAIT_IDLE} state_t;
`endif

  state_t                state;
  state_t                state_nxt;
  state_t                after_send;
  logic [7:0]            mem [DEPTH];
  logic [7:0]            data_q;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [TMO_W-1:0]      tmo_cnt;
  logic                  push;
  logic                  pop;

  assign full  = count[DEPTH_LOG2];
  assign empty = (count == '0);
  assign push  = wr_en && !full;
  assign pop   = (state == LOAD);

  // Storage is never reset; rd_ptr is stable outside LOAD->SEND, so data_q is valid in LOAD.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
    data_q <= mem[rd_ptr];
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      if (wr_en && full) begin
        overflow <= 1'b1;
      end else if (clear_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

`ifdef UART_TXQ_CRLF_EN
  logic cr_pend;

  // Remembers that the byte just handed to the uart was a CR, so an LF must follow it.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      cr_pend <= 1'b0;
    end else if (pop) begin
      cr_pend <= (data_q == 8'h0D);
    end else if (state == LF) begin
      cr_pend <= 1'b0;
    end
  end

  always_comb begin
    after_send = cr_pend ? LF : IDLE;
  end
`else
  always_comb begin
    after_send = IDLE;
  end
`endif

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (!empty && !is_transmitting) state_nxt = LOAD;
      LOAD:      state_nxt = SEND;
      SEND:      state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (is_transmitting) begin
          state_nxt = WAIT_IDLE;
        end else if (tmo_cnt == TMO_LAST) begin
          state_nxt = after_send;
        end
      end
      WAIT_IDLE: if (!is_transmitting) state_nxt = after_send;
`ifdef UART_TXQ_CRLF_EN
      LF:        state_nxt = WAIT_BUSY;
`endif
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    transmit = 1'b0;
    case (state)
      SEND:    transmit = 1'b1;
`ifdef UART_TXQ_CRLF_EN
      LF:      transmit = 1'b1;
`endif
      default: transmit = 1'b0;
    endcase
  end

  // tx_byte is loaded on the edge into a sending state so it is valid during the pulse.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      tx_byte <= 8'h00;
      tmo_cnt <= '0;
    end else begin
      if (pop) begin
        tx_byte <= data_q;
      end
`ifdef UART_TXQ_CRLF_EN
      else if (state_nxt == LF) begin
        tx_byte <= 8'h0A;
      end
`endif
      if (state == WAIT_BUSY) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end else begin
        tmo_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: queue-based reference model, a simple uart busy model, directed and random stimulus.
module tb_uart_tx_queue;
  localparam int DL2 = 2;
  localparam int D   = 1 << DL2;
  localparam int TMO = 4;
`ifdef UART_TXQ_CRLF_EN
  localparam bit CRLF = 1'b1;
`else
  localparam bit CRLF = 1'b0;
`endif

  logic           CLK = 1'b0;
  logic           reset_n = 1'b1;
  logic           wr_en = 1'b0;
  logic [7:0]     wr_data = 8'h00;
  logic           clear_overflow = 1'b0;
  logic           is_transmitting = 1'b0;
  logic           full;
  logic           empty;
  logic [DL2:0]   count;
  logic           overflow;
  logic           transmit;
  logic [7:0]     tx_byte;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [7:0] mq[$];
  logic [7:0] seen[$];
  logic [7:0] exp_seq[$];
  logic       exp_ovf = 1'b0;
  logic       lf_due = 1'b0;
  logic [7:0] last_tx = 8'h00;
  logic       prev_tx = 1'b0;
  int         cyc = 0;
  int         last_pulse_cyc = -1;
  // uart model: 0 = busy for busy_len cycles after a pulse, 1 = never busy, 2 = always busy
  int         uart_mode = 0;
  int         busy_len = 10;
  int         busy_left = 0;
  bit         start_pend = 1'b0;

  uart_tx_queue #(.DEPTH_LOG2(DL2), .BUSY_TIMEOUT(TMO)) dut (
    .CLK(CLK), .reset_n(reset_n), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .clear_overflow(clear_overflow), .transmit(transmit), .tx_byte(tx_byte),
    .is_transmitting(is_transmitting)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // One clock: apply the push to the model with pre-edge occupancy, then observe 1 time unit later.
  task automatic step();
    logic [7:0] b;
    bit ovf_push;
    @(posedge CLK);
    ovf_push = wr_en && (mq.size() >= D);
    if (ovf_push) exp_ovf = 1'b1;
    else if (clear_overflow) exp_ovf = 1'b0;
    if (wr_en && !ovf_push) mq.push_back(wr_data);
    #1;
    cyc++;
    if (transmit) begin
      check("no_back_to_back", 32'(prev_tx), 0);
      if (lf_due) begin
        check("lf_byte", 32'(tx_byte), 'h0A);
        lf_due = 1'b0;
      end else begin
        check("pulse_has_data", 32'(mq.size() != 0), 1);
        if (mq.size() != 0) begin
          b = mq.pop_front();
          check("tx_byte", 32'(tx_byte), 32'(b));
          if (CRLF && b == 8'h0D) lf_due = 1'b1;
        end
      end
      seen.push_back(tx_byte);
      last_tx = tx_byte;
      last_pulse_cyc = cyc;
    end else begin
      check("tx_hold", 32'(tx_byte), 32'(last_tx));
    end
    prev_tx = transmit;
    check("count", 32'(count), mq.size());
    check("empty", 32'(empty), 32'(mq.size() == 0));
    check("full", 32'(full), 32'(mq.size() == D));
    check("overflow", 32'(overflow), 32'(exp_ovf));
    if (uart_mode == 2) begin
      is_transmitting = 1'b1;
    end else begin
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) is_transmitting = 1'b0;
      end
      if (start_pend) begin
        is_transmitting = 1'b1;
        busy_left = busy_len;
        start_pend = 1'b0;
      end
      if (transmit && uart_mode == 0) start_pend = 1'b1;
    end
  endtask

  task automatic push(input logic [7:0] b);
    wr_en = 1'b1;
    wr_data = b;
    step();
    wr_en = 1'b0;
  endtask

  task automatic wait_pulse(input int after, input int budget);
    int n = 0;
    while (last_pulse_cyc <= after && n < budget) begin
      step();
      n++;
    end
    check("pulse_seen", 32'(last_pulse_cyc > after), 1);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((mq.size() != 0 || lf_due) && n < budget) begin
      step();
      n++;
    end
    check("drain_done", 32'(mq.size() != 0 || lf_due), 0);
    repeat (20) step();
  endtask

  task automatic check_seq(input int s);
    check("seq_len", seen.size() - s, exp_seq.size());
    for (int i = 0; i < exp_seq.size(); i++) begin
      if (s + i < seen.size()) check("seq_byte", 32'(seen[s + i]), 32'(exp_seq[i]));
    end
  endtask

  task automatic uart_idle(input int mode, input int len);
    uart_mode = mode;
    busy_len = len;
    busy_left = 0;
    start_pend = 1'b0;
    is_transmitting = (mode == 2);
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_transmit", 32'(transmit), 0);
    check("rst_tx_byte", 32'(tx_byte), 0);
    mq.delete();
    exp_ovf = 1'b0;
    lf_due = 1'b0;
    last_tx = 8'h00;
    prev_tx = 1'b0;
    uart_idle(0, 10);
    @(negedge CLK);
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    int s;
    int p;
    int acc;
    int max_cnt;
    do_reset();

    // single byte latency
    push(8'h41);
    acc = cyc - 1;
    wait_pulse(cyc, 10);
    check("latency", last_pulse_cyc - acc, 3);
    check("single_tx", 32'(last_tx), 'h41);
    drain(100);
    check("single_empty", 32'(empty), 1);

    // fill and overflow with the uart held busy
    uart_idle(2, 10);
    s = seen.size();
    for (int i = 1; i <= 5; i++) push(8'(i));
    check("fill_count", 32'(count), 4);
    check("fill_full", 32'(full), 1);
    check("fill_ovf", 32'(overflow), 1);
    clear_overflow = 1'b1;
    push(8'h06);
    clear_overflow = 1'b0;
    check("ovf_set_wins", 32'(overflow), 1);
    clear_overflow = 1'b1;
    step();
    clear_overflow = 1'b0;
    check("ovf_cleared", 32'(overflow), 0);
    uart_idle(0, 3);
    drain(200);
    exp_seq.delete();
    for (int i = 1; i <= 4; i++) exp_seq.push_back(8'(i));
    check_seq(s);

    // wrap-around in bursts of 3
    uart_idle(0, 1);
    s = seen.size();
    for (int i = 0; i < 10; i++) begin
      push(8'h10 + 8'(i));
      if (i % 3 == 2) repeat (12) step();
    end
    drain(200);
    exp_seq.delete();
    for (int i = 0; i < 10; i++) exp_seq.push_back(8'h10 + 8'(i));
    check_seq(s);
    check("wrap_no_ovf", 32'(overflow), 0);

    // third push lands on the LOAD->SEND edge of the first byte
    uart_idle(0, 10);
    s = seen.size();
    push(8'h21);
    push(8'h22);
    push(8'h23);
    check("simul_pulse", 32'(transmit), 1);
    check("simul_count", 32'(count), 2);
    p = last_pulse_cyc;
    wait_pulse(p, 40);
    check("b2b_gap", last_pulse_cyc - p, busy_len + 4);
    drain(200);
    exp_seq.delete();
    exp_seq.push_back(8'h21);
    exp_seq.push_back(8'h22);
    exp_seq.push_back(8'h23);
    check_seq(s);

    // uart never acknowledges: timeout then next byte
    uart_idle(1, 10);
    push(8'h55);
    push(8'h66);
    wait_pulse(cyc - 1, 10);
    p = last_pulse_cyc;
    check("tmo_first", 32'(last_tx), 'h55);
    wait_pulse(p, 30);
    check("tmo_gap", last_pulse_cyc - p, TMO + 3);
    check("tmo_second", 32'(last_tx), 'h66);
    uart_idle(0, 4);
    drain(100);

    // CR handling
    s = seen.size();
    max_cnt = 0;
    push(8'h0D);
    push(8'h42);
    for (int i = 0; i < 60; i++) begin
      if (int'(count) > max_cnt) max_cnt = int'(count);
      step();
    end
    check("cr_maxcnt", 32'(max_cnt <= 2), 1);
    exp_seq.delete();
    exp_seq.push_back(8'h0D);
    if (CRLF) exp_seq.push_back(8'h0A);
    exp_seq.push_back(8'h42);
    check_seq(s);

    // reset while a byte is being sent
    push(8'h31);
    push(8'h32);
    step();
    check("mid_pulse", 32'(transmit), 1);
    do_reset();
    push(8'h77);
    acc = cyc - 1;
    wait_pulse(cyc, 10);
    check("post_rst_latency", last_pulse_cyc - acc, 3);
    check("post_rst_tx", 32'(last_tx), 'h77);
    drain(100);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      if (i % 200 == 0) begin
        uart_mode = (i == 400) ? 1 : 0;
        busy_len = $urandom_range(6, 1);
      end
      wr_en = ($urandom_range(99, 0) < 35);
      wr_data = 8'($urandom);
      if ($urandom_range(19, 0) == 0) wr_data = 8'h0D;
      clear_overflow = ($urandom_range(19, 0) == 0);
      step();
    end
    wr_en = 1'b0;
    clear_overflow = 1'b0;
    uart_mode = 0;
    drain(1000);
    check("final_empty", 32'(empty), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
